// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared encodings for the CNN layer sequencer: FSM states, stage indices
// and the LED pattern shown before any classification has been latched.
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_GAP   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } seq_state_e;

    localparam int STG_CONV = 0;
    localparam int STG_POOL = 1;
    localparam int STG_FC   = 2;
    localparam int STG_RELU = 3;

    localparam int                   LED_MAX_W         = 32;
    localparam logic [LED_MAX_W-1:0] LED_RESET_PATTERN = '1;

endpackage

// File: rtl/cnn_layer_sequencer_watchdog.sv
// Up-counter with synchronous clear; o_expire flags the terminal count while
// enabled. Serves both as the per-stage timeout and as the result hold timer.
module seq_watchdog #(
    parameter int W    = 20,
    parameter int TERM = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [W-1:0] TERM_LAST = W'(TERM - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expire = i_en && (r_count == TERM_LAST);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Runs conv -> pool -> fc -> relu for each image of a batch, with a per-stage
// watchdog, capture strobes, a result hold period and the LED latch.
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int NUM_STAGES      = 4,
    parameter int CLASSIFICATIONS = 10,
    parameter int IMG_CNT_W       = 8,
    parameter int TIMEOUT_W       = 20,
    parameter int TIMEOUT_CYCLES  = 500000,
    parameter int HOLD_CYCLES     = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [IMG_CNT_W-1:0]       num_images,
    input  logic [NUM_STAGES-1:0]      stage_done,
    input  logic [CLASSIFICATIONS-1:0] class_hotcoded,
    output logic [NUM_STAGES-1:0]      stage_rst,
    output logic [NUM_STAGES-1:0]      stage_en,
    output logic [NUM_STAGES-1:0]      stage_capture,
    output logic                       image_advance,
    output logic [IMG_CNT_W-1:0]       image_idx,
    output logic [CLASSIFICATIONS-1:0] led,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 err_stage,
    output logic [2:0]                 state
);

    localparam int                         K_W      = 2;
    localparam logic [K_W-1:0]             K_LAST   = K_W'(NUM_STAGES - 1);
    localparam int                         HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [CLASSIFICATIONS-1:0] LED_RST  = LED_RESET_PATTERN[CLASSIFICATIONS-1:0];

    seq_state_e                 r_state, w_state_nxt;
    logic [K_W-1:0]             r_k, w_k_nxt;
    logic [IMG_CNT_W-1:0]       r_idx, w_idx_nxt;
    logic [IMG_CNT_W-1:0]       r_num, w_num_nxt;
    logic                       r_start_d;
    logic [CLASSIFICATIONS-1:0] r_class;

    logic [NUM_STAGES-1:0]      r_stage_rst, w_rst_nxt;
    logic [NUM_STAGES-1:0]      r_stage_en, w_en_nxt;
    logic [NUM_STAGES-1:0]      r_capture, w_cap_nxt;
    logic                       r_adv, w_adv_nxt;
    logic [CLASSIFICATIONS-1:0] r_led, w_led_nxt;
    logic                       r_busy, w_busy_nxt;
    logic                       r_done, w_done_nxt;
    logic                       r_error, w_error_nxt;
    logic [K_W-1:0]             r_err_stage, w_errstg_nxt;

    logic                       w_start_ok;
    logic                       w_to_expire;
    logic                       w_hold_expire;

    // Layers up to and including k keep running out of reset; later ones stay reset.
    function automatic logic [NUM_STAGES-1:0] rst_mask(input logic [K_W-1:0] k);
        logic [NUM_STAGES-1:0] m;
        for (int j = 0; j < NUM_STAGES; j++) begin
            m[j] = (j > int'(k));
        end
        return m;
    endfunction

    seq_watchdog #(.W(TIMEOUT_W), .TERM(TIMEOUT_CYCLES)) u_stage_wd (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state != ST_RUN),
        .i_en     (r_state == ST_RUN),
        .o_expire (w_to_expire)
    );

    seq_watchdog #(.W(HOLD_W), .TERM(HOLD_CYCLES)) u_hold_wd (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state != ST_HOLD),
        .i_en     (r_state == ST_HOLD),
        .o_expire (w_hold_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_idx       <= '0;
            r_num       <= '0;
            r_start_d   <= 1'b0;
            r_stage_rst <= '1;
            r_stage_en  <= '0;
            r_capture   <= '0;
            r_adv       <= 1'b0;
            r_led       <= LED_RST;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_stage <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_idx       <= w_idx_nxt;
            r_num       <= w_num_nxt;
            r_start_d   <= start;
            r_stage_rst <= w_rst_nxt;
            r_stage_en  <= w_en_nxt;
            r_capture   <= w_cap_nxt;
            r_adv       <= w_adv_nxt;
            r_led       <= w_led_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_err_stage <= w_errstg_nxt;
        end
    end

    // Relu's class vector is only valid alongside its done, so grab it on that edge.
    always_ff @(posedge clk) begin
        if (w_cap_nxt[STG_RELU]) begin
            r_class <= class_hotcoded;
        end
    end

    // In DONE a new batch needs a fresh rising edge of start.
    assign w_start_ok = start && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && !r_start_d));

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_idx_nxt   = r_idx;
        w_num_nxt   = r_num;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_k_nxt     = K_W'(STG_CONV);
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        w_num_nxt   = num_images;
                        w_k_nxt     = K_W'(STG_CONV);
                        w_idx_nxt   = '0;
                        w_state_nxt = (num_images == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stage_done[r_k]) begin
                        w_state_nxt = ST_GAP;
                    end else if (w_to_expire) begin
                        w_state_nxt = ST_ERROR;
                    end
                end
                ST_GAP: begin
                    if (r_k == K_LAST) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_k_nxt     = r_k + K_W'(1);
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (w_hold_expire) begin
                        if ((r_idx + IMG_CNT_W'(1)) == r_num) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + IMG_CNT_W'(1);
                            w_k_nxt     = K_W'(STG_CONV);
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                ST_ERROR: begin
                    w_state_nxt = ST_ERROR;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        w_rst_nxt    = '1;
        w_en_nxt     = '0;
        w_cap_nxt    = '0;
        w_adv_nxt    = 1'b0;
        w_led_nxt    = r_led;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_error_nxt  = 1'b0;
        w_errstg_nxt = '0;
        case (w_state_nxt)
            ST_RUN: begin
                w_en_nxt[w_k_nxt] = 1'b1;
                w_rst_nxt         = rst_mask(w_k_nxt);
                w_busy_nxt        = 1'b1;
            end
            ST_GAP: begin
                w_rst_nxt  = rst_mask(w_k_nxt);
                w_busy_nxt = 1'b1;
            end
            ST_HOLD: begin
                w_busy_nxt = 1'b1;
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
            end
            ST_ERROR: begin
                w_error_nxt  = 1'b1;
                w_errstg_nxt = r_k;
            end
            default: begin
                w_rst_nxt = '1;
            end
        endcase
        if ((r_state == ST_RUN) && (w_state_nxt == ST_GAP)) begin
            w_cap_nxt[r_k] = 1'b1;
        end
        if ((r_state == ST_HOLD) && (w_state_nxt != ST_HOLD) && (w_state_nxt != ST_IDLE)) begin
            w_adv_nxt = 1'b1;
        end
        if ((r_state == ST_GAP) && (w_state_nxt == ST_HOLD)) begin
            w_led_nxt = r_class;
        end
    end

    assign stage_rst     = r_stage_rst;
    assign stage_en      = r_stage_en;
    assign stage_capture = r_capture;
    assign image_advance = r_adv;
    assign image_idx     = r_idx;
    assign led           = r_led;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign err_stage     = r_err_stage;
    assign state         = r_state;

endmodule
